// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope with a two-stage sample scaling pipeline.
// A gate-driven state machine steps an 8-bit envelope level once per tick.
// Each offset-binary sample is scaled about midpoint 128 by that level.
module adsr_envelope #(
  parameter int TICK_CYCLES   = 100_000,
  parameter int ATTACK_STEP   = 4,
  parameter int DECAY_STEP    = 1,
  parameter int SUSTAIN_LEVEL = 192,
  parameter int RELEASE_STEP  = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       gate_in,
  input  logic [7:0] sample_in,
  output logic [7:0] dc_out,
  output logic [7:0] env_out,
  output logic [2:0] state_out,
  output logic       active_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0]     TICK_LAST     = CW'(TICK_CYCLES - 1);
  localparam logic [8:0]        ATTACK_STEP9  = 9'(ATTACK_STEP);
  localparam logic signed [9:0] DECAY_STEP10  = 10'(DECAY_STEP);
  localparam logic signed [9:0] SUSTAIN10     = 10'(SUSTAIN_LEVEL);
  localparam logic [7:0]        SUSTAIN8      = 8'(SUSTAIN_LEVEL);
  localparam logic [7:0]        RELEASE_STEP8 = 8'(RELEASE_STEP);

  logic [CW-1:0]      cnt_reg;
  logic               gate_q_reg;
  state_t             state_reg, state_next;
  logic [7:0]         env_reg, env_next;
  logic               active_reg;
  logic signed [16:0] p_reg;
  logic [7:0]         dc_reg;

  logic               tick;
  logic               rise;
  logic [8:0]         attack_sum;
  logic signed [9:0]  decay_diff;
  logic signed [16:0] d17, e17, p_next;

  assign tick = (cnt_reg == TICK_LAST);
  assign rise = gate_in & ~gate_q_reg;

  // Free-running tick divider, wraps after TICK_CYCLES-1.
  always_ff @(posedge clk_in) begin
    if (rst_in || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Next state and level: rise beats gate-low, gate-low beats the tick step.
  always_comb begin
    state_next = state_reg;
    env_next   = env_reg;
    attack_sum = {1'b0, env_reg} + ATTACK_STEP9;
    decay_diff = $signed({2'b00, env_reg}) - DECAY_STEP10;
    if (rise) begin
      // Retrigger keeps the current level so a held-over note does not click.
      state_next = ATTACK;
    end else if (!gate_in && (state_reg == ATTACK || state_reg == DECAY ||
                              state_reg == SUSTAIN)) begin
      state_next = RELEASE;
    end else if (tick) begin
      case (state_reg)
        IDLE: env_next = 8'd0;
        ATTACK: begin
          if (attack_sum >= 9'd255) begin
            env_next   = 8'd255;
            state_next = DECAY;
          end else begin
            env_next = attack_sum[7:0];
          end
        end
        DECAY: begin
          if (decay_diff <= SUSTAIN10) begin
            env_next   = SUSTAIN8;
            state_next = SUSTAIN;
          end else begin
            env_next = decay_diff[7:0];
          end
        end
        SUSTAIN: env_next = env_reg;
        RELEASE: begin
          if (env_reg <= RELEASE_STEP8) begin
            env_next   = 8'd0;
            state_next = IDLE;
          end else begin
            env_next = env_reg - RELEASE_STEP8;
          end
        end
        default: begin
          env_next   = 8'd0;
          state_next = IDLE;
        end
      endcase
    end
  end

  // Envelope state, level, activity flag and gate history.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg  <= IDLE;
      env_reg    <= 8'd0;
      active_reg <= 1'b0;
      gate_q_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      env_reg    <= env_next;
      active_reg <= (state_next != IDLE);
      gate_q_reg <= gate_in;
    end
  end

  // Signed product of (sample-128) and the currently registered level.
  assign d17    = $signed({9'b0, sample_in}) - 17'sd128;
  assign e17    = $signed({9'b0, env_reg});
  assign p_next = d17 * e17;

  // Two-stage scaling: product, then floor(p/256) re-centred on 128.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      p_reg  <= '0;
      dc_reg <= 8'd128;
    end else begin
      p_reg  <= p_next;
      dc_reg <= 8'((p_reg >>> 8) + 17'sd128);
    end
  end

  assign dc_out     = dc_reg;
  assign env_out    = env_reg;
  assign state_out  = state_reg;
  assign active_out = active_reg;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed test of the ADSR envelope: reset, attack, scaling, decay/sustain,
// release with retrigger, gate drop in attack, and reset in mid-note.
module tb_adsr_envelope;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       gate_in = 1'b0;
  logic [7:0] sample_in = 8'd128;
  logic [7:0] dc_out;
  logic [7:0] env_out;
  logic [2:0] state_out;
  logic       active_out;

  int pass_cnt = 0;
  int total_cnt = 0;

  adsr_envelope #(
    .TICK_CYCLES  (4),
    .ATTACK_STEP  (64),
    .DECAY_STEP   (40),
    .SUSTAIN_LEVEL(192),
    .RELEASE_STEP (50)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .gate_in   (gate_in),
    .sample_in (sample_in),
    .dc_out    (dc_out),
    .env_out   (env_out),
    .state_out (state_out),
    .active_out(active_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Waits (on negedges) until env_out differs from prev, at most 20 cycles.
  task automatic wait_env_change(input logic [7:0] prev, output int cycles);
    cycles = 0;
    while (env_out === prev && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; gate_in = 1'b1; sample_in = 8'hff;
    repeat (2) @(negedge clk);
    total_cnt++; if (dc_out !== 8'd128) $display("FAIL reset_dc: got %0d want 128", dc_out); else pass_cnt++;
    total_cnt++; if (env_out !== 8'd0) $display("FAIL reset_env: got %0d want 0", env_out); else pass_cnt++;
    total_cnt++; if (state_out !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_out); else pass_cnt++;
    total_cnt++; if (active_out !== 1'b0) $display("FAIL reset_active: got %0d want 0", active_out); else pass_cnt++;
    gate_in = 1'b0; sample_in = 8'd128; rst_in = 1'b0;
    repeat (2) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_attack();
    logic [7:0] exp_env [4];
    logic [7:0] last;
    int cyc;
    exp_env[0] = 8'd64; exp_env[1] = 8'd128; exp_env[2] = 8'd192; exp_env[3] = 8'd255;
    gate_in = 1'b1;
    @(negedge clk);
    total_cnt++; if (state_out !== 3'd1) $display("FAIL attack_enter_state: got %0d want 1", state_out); else pass_cnt++;
    total_cnt++; if (active_out !== 1'b1) $display("FAIL attack_active: got %0d want 1", active_out); else pass_cnt++;
    total_cnt++; if (env_out !== 8'd0) $display("FAIL attack_start_env: got %0d want 0", env_out); else pass_cnt++;
    last = 8'd0;
    for (int i = 0; i < 4; i++) begin
      wait_env_change(last, cyc);
      total_cnt++; if (env_out !== exp_env[i]) $display("FAIL attack_env%0d: got %0d want %0d", i, env_out, exp_env[i]); else pass_cnt++;
      if (i > 0) begin
        total_cnt++; if (cyc !== 4) $display("FAIL attack_tick_period%0d: got %0d want 4", i, cyc); else pass_cnt++;
      end
      last = exp_env[i];
    end
    total_cnt++; if (state_out !== 3'd2) $display("FAIL attack_to_decay: got %0d want 2", state_out); else pass_cnt++;
    $display("test_attack done");
  endtask

  // Runs in the four-cycle window where env sits at 255.
  task automatic test_scaling_full();
    sample_in = 8'd255;
    @(negedge clk);
    sample_in = 8'd0;
    @(negedge clk);
    total_cnt++; if (dc_out !== 8'd254) $display("FAIL scale_255: got %0d want 254", dc_out); else pass_cnt++;
    sample_in = 8'd128;
    @(negedge clk);
    total_cnt++; if (dc_out !== 8'd0) $display("FAIL scale_0: got %0d want 0", dc_out); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (dc_out !== 8'd128) $display("FAIL scale_128: got %0d want 128", dc_out); else pass_cnt++;
    $display("test_scaling_full done");
  endtask

  task automatic test_decay_sustain();
    int cyc;
    int bad;
    wait_env_change(8'd255, cyc);
    total_cnt++; if (env_out !== 8'd215) $display("FAIL decay_env0: got %0d want 215", env_out); else pass_cnt++;
    total_cnt++; if (state_out !== 3'd2) $display("FAIL decay_state: got %0d want 2", state_out); else pass_cnt++;
    wait_env_change(8'd215, cyc);
    total_cnt++; if (env_out !== 8'd192) $display("FAIL decay_env1: got %0d want 192", env_out); else pass_cnt++;
    total_cnt++; if (state_out !== 3'd3) $display("FAIL sustain_state: got %0d want 3", state_out); else pass_cnt++;
    sample_in = 8'd0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (env_out !== 8'd192 || state_out !== 3'd3) bad++;
    end
    total_cnt++; if (bad !== 0) $display("FAIL sustain_hold: got %0d bad cycles want 0", bad); else pass_cnt++;
    total_cnt++; if (dc_out !== 8'd32) $display("FAIL scale_sustain: got %0d want 32", dc_out); else pass_cnt++;
    sample_in = 8'd128;
    $display("test_decay_sustain done");
  endtask

  task automatic test_release_retrigger();
    int cyc;
    gate_in = 1'b0;
    @(negedge clk);
    total_cnt++; if (state_out !== 3'd4) $display("FAIL release_enter: got %0d want 4", state_out); else pass_cnt++;
    total_cnt++; if (env_out !== 8'd192) $display("FAIL release_no_step: got %0d want 192", env_out); else pass_cnt++;
    wait_env_change(8'd192, cyc);
    total_cnt++; if (env_out !== 8'd142) $display("FAIL release_env0: got %0d want 142", env_out); else pass_cnt++;
    wait_env_change(8'd142, cyc);
    total_cnt++; if (env_out !== 8'd92) $display("FAIL release_env1: got %0d want 92", env_out); else pass_cnt++;
    gate_in = 1'b1;
    @(negedge clk);
    total_cnt++; if (state_out !== 3'd1) $display("FAIL retrig_state: got %0d want 1", state_out); else pass_cnt++;
    total_cnt++; if (env_out !== 8'd92) $display("FAIL retrig_keep_env: got %0d want 92", env_out); else pass_cnt++;
    wait_env_change(8'd92, cyc);
    total_cnt++; if (env_out !== 8'd156) $display("FAIL retrig_env: got %0d want 156", env_out); else pass_cnt++;
    gate_in = 1'b0;
    cyc = 0;
    while (state_out !== 3'd0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    total_cnt++; if (state_out !== 3'd0) $display("FAIL fade_idle_state: got %0d want 0", state_out); else pass_cnt++;
    total_cnt++; if (env_out !== 8'd0) $display("FAIL fade_idle_env: got %0d want 0", env_out); else pass_cnt++;
    $display("test_release_retrigger done");
  endtask

  task automatic test_gate_drop_attack();
    int cyc;
    gate_in = 1'b1;
    @(negedge clk);
    wait_env_change(8'd0, cyc);
    total_cnt++; if (env_out !== 8'd64) $display("FAIL drop_att_env0: got %0d want 64", env_out); else pass_cnt++;
    wait_env_change(8'd64, cyc);
    total_cnt++; if (env_out !== 8'd128) $display("FAIL drop_att_env1: got %0d want 128", env_out); else pass_cnt++;
    gate_in = 1'b0;
    sample_in = 8'd255;
    @(negedge clk);
    total_cnt++; if (state_out !== 3'd4) $display("FAIL drop_state: got %0d want 4", state_out); else pass_cnt++;
    total_cnt++; if (env_out !== 8'd128) $display("FAIL drop_env: got %0d want 128", env_out); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (dc_out !== 8'd191) $display("FAIL scale_half: got %0d want 191", dc_out); else pass_cnt++;
    wait_env_change(8'd128, cyc);
    total_cnt++; if (env_out !== 8'd78) $display("FAIL drop_rel0: got %0d want 78", env_out); else pass_cnt++;
    wait_env_change(8'd78, cyc);
    total_cnt++; if (env_out !== 8'd28) $display("FAIL drop_rel1: got %0d want 28", env_out); else pass_cnt++;
    wait_env_change(8'd28, cyc);
    total_cnt++; if (env_out !== 8'd0) $display("FAIL drop_rel2: got %0d want 0", env_out); else pass_cnt++;
    total_cnt++; if (state_out !== 3'd0) $display("FAIL drop_idle: got %0d want 0", state_out); else pass_cnt++;
    total_cnt++; if (active_out !== 1'b0) $display("FAIL drop_inactive: got %0d want 0", active_out); else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++; if (dc_out !== 8'd128) $display("FAIL scale_env0: got %0d want 128", dc_out); else pass_cnt++;
    $display("test_gate_drop_attack done");
  endtask

  task automatic test_reset_mid_note();
    int cyc;
    gate_in = 1'b1;
    cyc = 0;
    while (state_out !== 3'd3 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    total_cnt++; if (state_out !== 3'd3) $display("FAIL midrst_reach_sustain: got %0d want 3", state_out); else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    total_cnt++; if (dc_out !== 8'd128) $display("FAIL midrst_dc: got %0d want 128", dc_out); else pass_cnt++;
    total_cnt++; if (env_out !== 8'd0) $display("FAIL midrst_env: got %0d want 0", env_out); else pass_cnt++;
    total_cnt++; if (state_out !== 3'd0) $display("FAIL midrst_state: got %0d want 0", state_out); else pass_cnt++;
    total_cnt++; if (active_out !== 1'b0) $display("FAIL midrst_active: got %0d want 0", active_out); else pass_cnt++;
    rst_in = 1'b0;
    @(negedge clk);
    total_cnt++; if (state_out !== 3'd1) $display("FAIL post_rst_rise: got %0d want 1", state_out); else pass_cnt++;
    gate_in = 1'b0;
    $display("test_reset_mid_note done");
  endtask

  initial begin
    test_reset();
    test_attack();
    test_scaling_full();
    test_decay_sustain();
    test_release_retrigger();
    test_gate_drop_attack();
    test_reset_mid_note();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
